ifetch_pq: RTL and testbench

Parametrised prefetching instruction fetch stage for the bexkat1 pipeline, and the successor to the single-word `ifetch`. It runs Wishbone-classic reads ahead of decode into a DEPTH-word queue and assembles short (one-word) and long (two-word, immediate-carrying) instructions into the 64-bit IR. It presents one instruction per cycle to `idecode` and handles stall, redirect (`pc_set`) and flush. It sits between the instruction port of `ram2` and `idecode`.

---
 rtl/ifetch_pq.sv | 85 ++++++++
 tb/tb_ifetch_pq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ifetch_pq.sv
// ifetch_pq: prefetching instruction fetch queue assembling short/long instructions into a 64-bit IR
module ifetch_pq #(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int LONG_BIT = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        pc_set,
  input  logic [31:0] pc_in,
  output logic [63:0] ir,
  output logic [31:0] pc,
  output logic        bus_cyc,
  output logic [31:0] bus_adr,
  input  logic        bus_ack,
  input  logic [31:0] bus_in
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] q_word [DEPTH];
  logic [31:0] q_adr [DEPTH];
  logic [AW-1:0] wp, rp, rp1;
  logic [AW:0] count, count_next;
  logic drop;
  logic [31:0] tgt, target, w0, w1, a0;
  logic issue, pop1, pop2, push;
  always_comb begin
    rp1 = rp + 1'b1;
    w0 = q_word[rp];
    w1 = q_word[rp1];
    a0 = q_adr[rp];
    target = pc_in & ~32'h3;
    issue = !stall_i && !pc_set;
    pop1 = issue && count != '0 && !w0[LONG_BIT];
    pop2 = issue && count > (AW+1)'(1) && w0[LONG_BIT];
    push = bus_cyc && bus_ack && !drop && !pc_set;
    count_next = count + (AW+1)'(push) - (AW+1)'(pop1) - (AW+1)'({pop2, 1'b0});
  end
  always_ff @(posedge clk_i)
    if (push) begin
      q_word[wp] <= bus_in;
      q_adr[wp] <= bus_adr;
    end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ir <= '0;
      pc <= RESET_PC;
      bus_cyc <= 1'b0;
      bus_adr <= RESET_PC;
      wp <= '0;
      rp <= '0;
      count <= '0;
      drop <= 1'b0;
      tgt <= RESET_PC;
    end else if (pc_set) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      ir <= '0;
      pc <= target;
      if (bus_cyc && !bus_ack) begin
        drop <= 1'b1;
        tgt <= target;
      end else begin
        drop <= 1'b0;
        bus_cyc <= 1'b0;
        bus_adr <= target;
      end
    end else begin
      if (push)
        wp <= wp + 1'b1;
      if (bus_cyc && bus_ack) begin
        bus_adr <= drop ? tgt : bus_adr + 32'd4;
        drop <= 1'b0;
      end
      bus_cyc <= count_next < (AW+1)'(DEPTH);
      count <= count_next;
      rp <= rp + AW'({pop2, pop1});
      if (issue) begin
        ir <= pop2 ? {w1, w0} : pop1 ? {32'h0, w0} : 64'h0;
        pc <= pop2 ? a0 + 32'd8 : pop1 ? a0 + 32'd4 : pc;
      end
    end
  end
endmodule

// File: tb/tb_ifetch_pq.sv
// tb_ifetch_pq: randomized and directed checks of ifetch_pq against a queue-based reference model
module tb_ifetch_pq;
  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h100;
  logic clk = 0, rst_i = 1, stall_i = 0, pc_set = 0, bus_ack = 0;
  logic [31:0] pc_in = 0, bus_in, pc, bus_adr;
  logic [63:0] ir;
  logic bus_cyc;
  logic [63:0] w_ir;
  logic [31:0] w_pc, w_adr;
  logic w_cyc;
  int checks = 0, failures = 0;
  logic [31:0] mq_w[$], mq_a[$];
  logic m_cyc, m_drop;
  logic [31:0] m_adr, m_tgt, m_pc;
  logic [63:0] m_ir;
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h100: return 32'h1000_0000;
      32'h104: return 32'h1100_0000;
      32'h200: return 32'h0000_0001;
      32'h204: return 32'hDEAD_BEEF;
      default: return a < 32'h10000 ? a << 4 : (a * 32'h9E37_79B1) ^ (a >> 7);
    endcase
  endfunction
  assign bus_in = mem(bus_adr);
  ifetch_pq #(.DEPTH(DEPTH), .RESET_PC(RPC), .LONG_BIT(0)) dut (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .pc_set(pc_set), .pc_in(pc_in),
    .ir(ir), .pc(pc), .bus_cyc(bus_cyc), .bus_adr(bus_adr), .bus_ack(bus_ack), .bus_in(bus_in)
  );
  ifetch_pq #(.DEPTH(2), .RESET_PC(32'hFFFF_FFFC), .LONG_BIT(0)) wrap_dut (
    .clk_i(clk), .rst_i(rst_i), .stall_i(1'b0), .pc_set(1'b0), .pc_in(32'h0),
    .ir(w_ir), .pc(w_pc), .bus_cyc(w_cyc), .bus_adr(w_adr), .bus_ack(1'b1), .bus_in(32'h1000_0000)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_step();
    logic [31:0] t;
    t = {pc_in[31:2], 2'b00};
    if (rst_i) begin
      mq_w.delete(); mq_a.delete();
      m_cyc = 0; m_drop = 0; m_adr = RPC; m_tgt = RPC; m_pc = RPC; m_ir = 0;
    end else if (pc_set) begin
      mq_w.delete(); mq_a.delete();
      m_ir = 0; m_pc = t;
      if (m_cyc && !bus_ack) begin
        m_drop = 1; m_tgt = t;
      end else begin
        m_drop = 0; m_cyc = 0; m_adr = t;
      end
    end else begin
      if (!stall_i) begin
        if (mq_w.size() >= 1 && !mq_w[0][0]) begin
          m_ir = {32'h0, mq_w[0]}; m_pc = mq_a[0] + 4;
          void'(mq_w.pop_front()); void'(mq_a.pop_front());
        end else if (mq_w.size() >= 2 && mq_w[0][0]) begin
          m_ir = {mq_w[1], mq_w[0]}; m_pc = mq_a[0] + 8;
          repeat (2) begin void'(mq_w.pop_front()); void'(mq_a.pop_front()); end
        end else
          m_ir = 0;
      end
      if (m_cyc && bus_ack) begin
        if (!m_drop) begin mq_w.push_back(mem(m_adr)); mq_a.push_back(m_adr); end
        m_adr = m_drop ? m_tgt : m_adr + 4;
        m_drop = 0;
      end
      m_cyc = mq_w.size() < DEPTH;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_ir", ir, m_ir);
    chk("model_pc", {32'h0, pc}, {32'h0, m_pc});
    chk("model_cyc", {63'h0, bus_cyc}, {63'h0, m_cyc});
    chk("model_adr", {32'h0, bus_adr}, {32'h0, m_adr});
  endtask
  initial begin
    tick(); tick();
    chk("rst_ir", ir, 64'h0);
    chk("rst_pc", {32'h0, pc}, 64'h100);
    chk("rst_cyc", {63'h0, bus_cyc}, 64'h0);
    chk("rst_adr", {32'h0, bus_adr}, 64'h100);
    rst_i = 0; bus_ack = 1;
    tick();
    chk("e1_cyc", {63'h0, bus_cyc}, 64'h1);
    chk("e1_adr", {32'h0, bus_adr}, 64'h100);
    chk("wrap_adr0", {32'h0, w_adr}, 64'hFFFF_FFFC);
    tick();
    chk("e2_adr", {32'h0, bus_adr}, 64'h104);
    chk("wrap_adr1", {32'h0, w_adr}, 64'h0);
    tick();
    chk("first_ir", ir, 64'h0000_0000_1000_0000);
    chk("first_pc", {32'h0, pc}, 64'h104);
    chk("wrap_pc", {32'h0, w_pc}, 64'h0);
    tick();
    chk("second_ir", ir, 64'h0000_0000_1100_0000);
    chk("second_pc", {32'h0, pc}, 64'h108);
    pc_set = 1; pc_in = 32'h200;
    tick();
    pc_set = 0;
    tick(); tick();
    bus_ack = 0;
    repeat (3) begin tick(); chk("long_wait_ir", ir, 64'h0); end
    bus_ack = 1;
    tick();
    chk("long_half_ir", ir, 64'h0);
    bus_ack = 0;
    tick();
    chk("long_ir", ir, 64'hDEAD_BEEF_0000_0001);
    chk("long_pc", {32'h0, pc}, 64'h208);
    bus_ack = 1; pc_set = 1; pc_in = 32'h300;
    tick();
    pc_set = 0; stall_i = 1;
    repeat (10) begin
      tick();
      chk("stall_ir", ir, 64'h0);
      chk("stall_pc", {32'h0, pc}, 64'h300);
    end
    chk("stall_full_cyc", {63'h0, bus_cyc}, 64'h0);
    stall_i = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("drain_ir", ir, {32'h0, (32'h300 + 32'(4 * k)) << 4});
      chk("drain_pc", {32'h0, pc}, {32'h0, 32'h304 + 32'(4 * k)});
    end
    pc_set = 1; pc_in = 32'h40;
    tick();
    pc_set = 0; bus_ack = 0;
    tick();
    chk("open40_adr", {32'h0, bus_adr}, 64'h40);
    tick();
    pc_set = 1; pc_in = 32'h2002;
    tick();
    chk("drop_pc", {32'h0, pc}, 64'h2000);
    chk("drop_adr_held", {32'h0, bus_adr}, 64'h40);
    chk("drop_cyc_open", {63'h0, bus_cyc}, 64'h1);
    pc_set = 0;
    tick();
    bus_ack = 1;
    tick();
    chk("drop_new_adr", {32'h0, bus_adr}, 64'h2000);
    tick(); tick();
    chk("drop_ir", ir, 64'h0000_0000_0002_0000);
    chk("drop_first_pc", {32'h0, pc}, 64'h2004);
    stall_i = 1; pc_set = 1; pc_in = 32'h500;
    tick();
    chk("same_ir", ir, 64'h0);
    chk("same_pc", {32'h0, pc}, 64'h500);
    chk("same_cyc", {63'h0, bus_cyc}, 64'h0);
    chk("same_adr", {32'h0, bus_adr}, 64'h500);
    stall_i = 0; pc_set = 0;
    tick();
    chk("same_restart_cyc", {63'h0, bus_cyc}, 64'h1);
    tick(); tick();
    chk("same_ir2", ir, 64'h0000_0000_0000_5000);
    chk("same_pc2", {32'h0, pc}, 64'h504);
    for (int i = 0; i < 3000; i++) begin
      rst_i = $urandom_range(0, 999) < 3;
      stall_i = $urandom_range(0, 3) == 0;
      pc_set = $urandom_range(0, 29) == 0;
      pc_in = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 32'hFFFF);
      bus_ack = $urandom_range(0, 9) < 6;
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
